// File: rtl/riot_pkg.sv
// Shared constants and bus-access decode for the 6532 timer register front end.
// Used by riot_timer_bus and riot_edge_det.
package riot_pkg;

    typedef enum logic [1:0] {
        C_TIM_0001T = 2'b00,
        C_TIM_0008T = 2'b01,
        C_TIM_0064T = 2'b10,
        C_TIM_1024T = 2'b11
    } tim_mode_e;

    localparam int A_TIM_SEL = 2;
    localparam int A_WR_TIM  = 4;
    localparam int A_IRQ_EN  = 3;
    localparam int A_FLAG    = 0;
    localparam int A_EDG_POL = 0;
    localparam int A_PA7_IE  = 1;

    localparam int TF_BIT = 7;
    localparam int PF_BIT = 6;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_TIM_WR,
        ACC_EDG_WR,
        ACC_TIM_RD,
        ACC_FLG_RD
    } acc_e;

    function automatic acc_e decode_access(input logic cs, input logic rw, input logic [4:0] a);
        acc_e acc;
        acc = ACC_NONE;
        if (cs && a[A_TIM_SEL]) begin
            if (!rw)
                acc = a[A_WR_TIM] ? ACC_TIM_WR : ACC_EDG_WR;
            else
                acc = a[A_FLAG] ? ACC_FLG_RD : ACC_TIM_RD;
        end
        return acc;
    endfunction

endpackage

// File: rtl/riot_edge_det.sv
// PA7 synchronizer, history flop and arm counter producing a one-cycle pulse
// on the edge polarity selected by edg (0 = falling, 1 = rising).
module riot_edge_det
    import riot_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RES_N,
    input  logic PA7,
    input  logic edg,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [1:0]             arm_q;
    logic                   sync_out;
    logic                   rise;
    logic                   fall;

    // Synchronizer resets high so a low pin after reset looks like a falling
    // edge; the arm counter masks that until the chain has flushed.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            sync_q <= '1;
            hist_q <= 1'b1;
            arm_q  <= 2'd0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PA7};
            hist_q <= sync_q[SYNC_STAGES-1];
            if (arm_q != 2'd3)
                arm_q <= arm_q + 2'd1;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = !hist_q && sync_out;
    assign fall     = hist_q && !sync_out;
    assign pulse    = (arm_q == 2'd3) && (edg ? rise : fall);

endmodule

// File: rtl/riot_timer_bus.sv
// 6532 interval-timer register front end: bus decode, TF/PF flags and IRQ_N.
// PA7 edge interrupt logic is present only when RIOT_PA7_IRQ_EN is defined.
module riot_timer_bus
    import riot_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RES_N,
    input  logic       CS,
    input  logic       RW,
    input  logic [4:0] A,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    input  logic [7:0] TIM_CNT,
    output logic       TIM_WE,
    output logic [1:0] TIM_MODE,
    output logic [7:0] TIM_IN,
    input  logic       PA7,
    output logic       IRQ_N
);

    acc_e acc;
    logic tie_q;
    logic tf_q;
    logic wr_d_q;
    logic [7:0] cnt_prev_q;
    logic underflow;
    logic pf_q;
    logic pie_q;

    assign acc      = decode_access(CS, RW, A);
    assign TIM_WE   = (acc == ACC_TIM_WR);
    assign TIM_MODE = A[1:0];
    assign TIM_IN   = DIN;

    // NOTE: DOUT gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        DOUT = 8'h00;
        case (acc)
            ACC_TIM_RD: DOUT = TIM_CNT;
            ACC_FLG_RD: begin
                DOUT[TF_BIT] = tf_q;
                DOUT[PF_BIT] = pf_q;
            end
            default: DOUT = 8'h00;
        endcase
    end

    // A freshly loaded 8'hFF after a count of 00 is not an underflow.
    assign underflow = (cnt_prev_q == 8'h00) && (TIM_CNT == 8'hFF) && !wr_d_q;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            tie_q      <= 1'b0;
            tf_q       <= 1'b0;
            wr_d_q     <= 1'b0;
            cnt_prev_q <= 8'h00;
        end else begin
            cnt_prev_q <= TIM_CNT;
            wr_d_q     <= TIM_WE;
            if (acc == ACC_TIM_WR || acc == ACC_TIM_RD)
                tie_q <= A[A_IRQ_EN];
            // Set dominates clear so an underflow during an access is kept.
            tf_q <= underflow || (tf_q && !(acc == ACC_TIM_WR || acc == ACC_TIM_RD));
        end
    end

`ifdef RIOT_PA7_IRQ_EN
    logic edg_q;
    logic pa7_pulse;

    riot_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_det (
        .CLK   (CLK),
        .RES_N (RES_N),
        .PA7   (PA7),
        .edg   (edg_q),
        .pulse (pa7_pulse)
    );

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            edg_q <= 1'b0;
            pie_q <= 1'b0;
            pf_q  <= 1'b0;
        end else begin
            if (acc == ACC_EDG_WR) begin
                edg_q <= A[A_EDG_POL];
                pie_q <= A[A_PA7_IE];
            end
            pf_q <= pa7_pulse || (pf_q && (acc != ACC_FLG_RD));
        end
    end
`else
    logic unused_pa7;
    localparam int UNUSED_SYNC_STAGES = SYNC_STAGES;

    assign unused_pa7 = PA7;
    assign pf_q       = 1'b0;
    assign pie_q      = 1'b0;
`endif

    assign IRQ_N = !((tf_q && tie_q) || (pf_q && pie_q));

endmodule

// File: tb/tb_riot_timer_bus.sv
// Self-checking bench for riot_timer_bus: table of single-cycle bus vectors
// plus hand sequences for set-wins, PA7 edge timing and asynchronous reset.
module tb_riot_timer_bus;

`ifdef RIOT_PA7_IRQ_EN
    localparam bit PA7_EN = 1'b1;
`else
    localparam bit PA7_EN = 1'b0;
`endif

    logic       CLK;
    logic       RES_N;
    logic       CS;
    logic       RW;
    logic [4:0] A;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic [7:0] TIM_CNT;
    logic       TIM_WE;
    logic [1:0] TIM_MODE;
    logic [7:0] TIM_IN;
    logic       PA7;
    logic       IRQ_N;

    int errors = 0;
    int checks = 0;

    riot_timer_bus #(.SYNC_STAGES(2)) dut (
        .CLK      (CLK),
        .RES_N    (RES_N),
        .CS       (CS),
        .RW       (RW),
        .A        (A),
        .DIN      (DIN),
        .DOUT     (DOUT),
        .TIM_CNT  (TIM_CNT),
        .TIM_WE   (TIM_WE),
        .TIM_MODE (TIM_MODE),
        .TIM_IN   (TIM_IN),
        .PA7      (PA7),
        .IRQ_N    (IRQ_N)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       cs;
        logic       rw;
        logic [4:0] a;
        logic [7:0] din;
        logic [7:0] cnt;
        logic [7:0] exp_dout;
        logic       exp_we;
        logic [1:0] exp_mode;
        logic       exp_irq_n;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic bus(input logic cs, input logic rw, input logic [4:0] a,
                       input logic [7:0] din, input logic [7:0] cnt);
        CS      = cs;
        RW      = rw;
        A       = a;
        DIN     = din;
        TIM_CNT = cnt;
    endtask

    task automatic idle(input logic [7:0] cnt);
        bus(1'b0, 1'b1, 5'b00000, 8'h00, cnt);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //                cs    rw    a         din    cnt    dout   we    mode   irq_n
        vecs[0]  = '{1'b1, 1'b1, 5'b00101, 8'h00, 8'h10, 8'h00, 1'b0, 2'b01, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 5'b11100, 8'h03, 8'h10, 8'h00, 1'b1, 2'b00, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 5'b00000, 8'h00, 8'h03, 8'h00, 1'b0, 2'b00, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 5'b00000, 8'h00, 8'h02, 8'h00, 1'b0, 2'b00, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 5'b00000, 8'h00, 8'h01, 8'h00, 1'b0, 2'b00, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 5'b00000, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 5'b00000, 8'h00, 8'hFF, 8'h00, 1'b0, 2'b00, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 5'b00000, 8'h00, 8'hFE, 8'h00, 1'b0, 2'b00, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 5'b00101, 8'h00, 8'hFD, 8'h80, 1'b0, 2'b01, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 5'b00100, 8'h00, 8'hFC, 8'hFC, 1'b0, 2'b00, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 5'b00000, 8'h00, 8'hFB, 8'h00, 1'b0, 2'b00, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 5'b00101, 8'h00, 8'hFA, 8'h00, 1'b0, 2'b01, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 5'b11100, 8'hFF, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 5'b00000, 8'h00, 8'hFF, 8'h00, 1'b0, 2'b00, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 5'b00000, 8'h00, 8'hFE, 8'h00, 1'b0, 2'b00, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 5'b00101, 8'h00, 8'hFE, 8'h00, 1'b0, 2'b01, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 5'b10111, 8'h05, 8'hFE, 8'h00, 1'b1, 2'b11, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 5'b11110, 8'h22, 8'h05, 8'h00, 1'b1, 2'b10, 1'b1};
        vecs[18] = '{1'b1, 1'b1, 5'b00000, 8'h00, 8'h22, 8'h00, 1'b0, 2'b00, 1'b1};
        vecs[19] = '{1'b1, 1'b1, 5'b01100, 8'h00, 8'h21, 8'h21, 1'b0, 2'b00, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 5'b00000, 8'h00, 8'h20, 8'h00, 1'b0, 2'b00, 1'b1};

        RES_N = 1'b0;
        PA7   = 1'b0;
        idle(8'h10);

        // Reset state, held asynchronously before any clock edge.
        #3;
        check("rst irq_n", {7'd0, IRQ_N}, 8'h01);
        check("rst tim_we", {7'd0, TIM_WE}, 8'h00);
        check("rst dout", DOUT, 8'h00);
        step();
        step();
        RES_N = 1'b1;
        repeat (5) step();
        bus(1'b1, 1'b1, 5'b00101, 8'h00, 8'h10);
        #1;
        check("post-rst flag read", DOUT, 8'h00);
        check("post-rst irq_n", {7'd0, IRQ_N}, 8'h01);
        idle(8'h10);
        step();

        // Table-driven timer accesses.
        for (int i = 0; i < 21; i++) begin
            bus(vecs[i].cs, vecs[i].rw, vecs[i].a, vecs[i].din, vecs[i].cnt);
            #1;
            check($sformatf("row%0d dout", i), DOUT, vecs[i].exp_dout);
            check($sformatf("row%0d tim_we", i), {7'd0, TIM_WE}, {7'd0, vecs[i].exp_we});
            check($sformatf("row%0d irq_n", i), {7'd0, IRQ_N}, {7'd0, vecs[i].exp_irq_n});
            if (vecs[i].exp_we) begin
                check($sformatf("row%0d tim_mode", i), {6'd0, TIM_MODE}, {6'd0, vecs[i].exp_mode});
                check($sformatf("row%0d tim_in", i), TIM_IN, vecs[i].din);
            end
            step();
        end

        // Underflow coincident with a timer read: set wins over clear.
        idle(8'h01); step();
        idle(8'h00); step();
        bus(1'b1, 1'b1, 5'b01100, 8'h00, 8'hFF);
        #1;
        check("uf+rd dout", DOUT, 8'hFF);
        step();
        idle(8'hFE);
        #1;
        check("uf+rd irq_n", {7'd0, IRQ_N}, 8'h00);
        step();
        bus(1'b1, 1'b1, 5'b00101, 8'h00, 8'hFD);
        #1;
        check("uf+rd flags", DOUT, 8'h80);
        step();
        bus(1'b1, 1'b1, 5'b00100, 8'h00, 8'hFC);
        step();
        idle(8'hFB);
        #1;
        check("tf clr irq_n", {7'd0, IRQ_N}, 8'h01);

        // Edge control write: rising edge, PA7 interrupt enabled.
        bus(1'b1, 1'b0, 5'b00111, 8'h00, 8'hFB);
        #1;
        check("edg wr tim_we", {7'd0, TIM_WE}, 8'h00);
        step();
        idle(8'hFB);
        PA7 = 1'b1;
        step();
        check("pa7 +1 irq_n", {7'd0, IRQ_N}, 8'h01);
        step();
        check("pa7 +2 irq_n", {7'd0, IRQ_N}, 8'h01);
        step();
        check("pa7 +3 irq_n", {7'd0, IRQ_N}, {7'd0, !PA7_EN});
        bus(1'b1, 1'b1, 5'b00101, 8'h00, 8'hFB);
        #1;
        check("pa7 flag read", DOUT, PA7_EN ? 8'h40 : 8'h00);
        step();
        idle(8'hFB);
        #1;
        check("pf clr irq_n", {7'd0, IRQ_N}, 8'h01);
        bus(1'b1, 1'b1, 5'b00101, 8'h00, 8'hFB);
        #1;
        check("pf clr flags", DOUT, 8'h00);
        step();

        // PA7 edge coincident with a flag read: set wins over clear.
        idle(8'hFB);
        PA7 = 1'b0;
        repeat (4) step();
        PA7 = 1'b1;
        step();
        step();
        bus(1'b1, 1'b1, 5'b00101, 8'h00, 8'hFB);
        #1;
        check("edge+rd flags", DOUT, 8'h00);
        step();
        #1;
        check("edge+rd keep", DOUT, PA7_EN ? 8'h40 : 8'h00);
        step();
        idle(8'hFB);
        #1;
        check("edge+rd irq_n", {7'd0, IRQ_N}, 8'h01);

        // Both flags set mid-count, then asynchronous reset.
        bus(1'b1, 1'b0, 5'b11100, 8'h02, 8'hFB);
        PA7 = 1'b0;
        step();
        idle(8'h02); step();
        idle(8'h01); step();
        idle(8'h00); step();
        idle(8'hFF);
        PA7 = 1'b1;
        step();
        idle(8'hFE); step();
        idle(8'hFD); step();
        bus(1'b1, 1'b1, 5'b00101, 8'h00, 8'hFC);
        #1;
        check("pre-rst flags", DOUT, PA7_EN ? 8'hC0 : 8'h80);
        check("pre-rst irq_n", {7'd0, IRQ_N}, 8'h00);
        #1;
        RES_N = 1'b0;
        #1;
        check("async rst irq_n", {7'd0, IRQ_N}, 8'h01);
        check("async rst flags", DOUT, 8'h00);
        #2;
        RES_N = 1'b1;
        idle(8'hFC);
        step();
        step();
        bus(1'b1, 1'b1, 5'b00101, 8'h00, 8'hFB);
        #1;
        check("after rst flags", DOUT, 8'h00);
        check("after rst irq_n", {7'd0, IRQ_N}, 8'h01);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
